// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with flags; optional iterative shift-add multiplier.
// Latency: 1 cycle for single-cycle ops, N cycles for MUL (only when ALU_MUL_EN is defined).
// Backpressure: a result is held stable until out_ready; in_ready follows out_ready in HOLD, 0 in MUL.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake; a, b, sel are sampled only on accept
//   a, b [N-1:0]         operands (b[S-1:0] is the shift amount for shifts)
//   sel [3:0]            opcode
//   out_valid/out_ready  result handshake
//   result [N-1:0]       registered result; z, n, v, c registered flags
//
// Build option: define ALU_MUL_EN to compile in the multiplier (opcode 12).
// Without it, opcode 12 behaves as a reserved opcode (result 0, z=1).
`timescale 1ns/1ps
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         z,
  output logic         n,
  output logic         v,
  output logic         c
);

  localparam int S = $clog2(N);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_PASB = 4'd7;
  localparam logic [3:0] OP_PASA = 4'd8;
  localparam logic [3:0] OP_VCC  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_ASR  = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd13;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd12;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1} state_t;
`endif

  state_t state, state_nxt;
  state_t acc_state;     // state entered when an operation is accepted
  logic   accept;
  logic   load_alu;

  // ---------------- single-cycle datapath ----------------
  logic [S-1:0]        amt;
  logic [N:0]          sum_add, sum_sub;
  logic [N:0]          shl_w, shr_w;
  logic signed [N:0]   asr_w;
  logic [N-1:0]        alu_res;
  logic [N-1:0]        alu_fsrc;  // value the z/n flags are derived from
  logic                alu_v, alu_c;

  assign amt = b[S-1:0];

  always_comb begin
    sum_add  = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so the carry out means "no borrow".
    sum_sub  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    // One guard bit on the exit side of each shift catches the last bit shifted out;
    // with amt == 0 the guard bit stays 0, giving c = 0.
    shl_w    = {1'b0, a} << amt;
    shr_w    = {a, 1'b0} >> amt;
    asr_w    = $signed({a, 1'b0}) >>> amt;

    alu_res  = '0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    case (sel)
      OP_NOP:  alu_res = '0;
      OP_ADD: begin
        alu_res = sum_add[N-1:0];
        alu_c   = sum_add[N];
        alu_v   = (a[N-1] == b[N-1]) && (sum_add[N-1] != a[N-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sum_sub[N-1:0];
        alu_c   = sum_sub[N];
        alu_v   = (a[N-1] != b[N-1]) && (sum_sub[N-1] != a[N-1]);
      end
      OP_SHL: begin
        alu_res = shl_w[N-1:0];
        alu_c   = shl_w[N];
      end
      OP_SHR: begin
        alu_res = shr_w[N:1];
        alu_c   = shr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[N:1];
        alu_c   = asr_w[0];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_PASB: alu_res = b;
      OP_PASA: alu_res = a;
      OP_VCC:  alu_res = '1;
      default: alu_res = '0;   // reserved opcodes
    endcase

    // CMP flags come from the difference; the reported result is a itself.
    alu_fsrc = alu_res;
    if (sel == OP_CMP) begin
      alu_res = a;
    end
  end

  // ---------------- multiplier ----------------
`ifdef ALU_MUL_EN
  logic [2*N-1:0] acc, mcand, acc_nxt;
  logic [N-1:0]   mplier;
  logic [S-1:0]   cnt;
  logic           mul_last;

  // Shift-add: multiplicand moves left, multiplier moves right, one bit per cycle.
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == S'(N - 1));
  assign acc_state = (sel == OP_MUL) ? ST_MUL : ST_HOLD;
`else
  assign acc_state = ST_HOLD;
`endif

  assign accept   = in_valid && in_ready;
  assign load_alu = accept && (acc_state == ST_HOLD);

  // ---------------- control ----------------
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = acc_state;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? acc_state : ST_IDLE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_last) state_nxt = ST_HOLD;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      result <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      v      <= 1'b0;
      c      <= 1'b0;
`ifdef ALU_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (load_alu) begin
        result <= alu_res;
        z      <= (alu_fsrc == '0);
        n      <= alu_fsrc[N-1];
        v      <= alu_v;
        c      <= alu_c;
      end
`ifdef ALU_MUL_EN
      if (accept && (acc_state == ST_MUL)) begin
        acc    <= '0;
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
      end else if (state == ST_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + S'(1);   // wraps back to 0 after the last step
        if (mul_last) begin
          result <= acc_nxt[N-1:0];
          z      <= (acc_nxt[N-1:0] == '0);
          n      <= acc_nxt[N-1];
          v      <= |acc_nxt[2*N-1:N];
          c      <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int N = 8;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_PASB = 4'd7;
  localparam logic [3:0] OP_PASA = 4'd8, OP_VCC = 4'd9,  OP_XOR = 4'd10, OP_ASR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_CMP = 4'd13, OP_RSV = 4'd15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         z, n, v, c;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .n(n), .v(v), .c(c)
  );

  always #5 clk = ~clk;

  typedef struct { string nm; logic [7:0] res; logic [3:0] znvc; } exp_t;
  typedef struct { string nm; logic [31:0] act; logic [31:0] want; } probe_t;

  exp_t   exp_q[$];
  probe_t prb_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  exp_t   e;
  probe_t p;

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    while (prb_q.size() > 0) begin
      p = prb_q.pop_front();
      n_chk++;
      if (p.act === p.want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", p.nm, p.act, p.want);
    end
    if (out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got res=%h znvc=%b, no result pending", result, {z, n, v, c});
      end else begin
        e = exp_q.pop_front();
        if (result === e.res && {z, n, v, c} === e.znvc) n_pass++;
        else $display("FAIL %s: got res=%h znvc=%b, expected res=%h znvc=%b",
                      e.nm, result, {z, n, v, c}, e.res, e.znvc);
      end
    end
  end

  task automatic probe(input string nm, input logic [31:0] act, input logic [31:0] want);
    prb_q.push_back('{nm, act, want});
  endtask

  // Offer an op, wait (bounded) for in_ready, complete the accept edge,
  // then queue the expected response if chk is set. Returns 1ns after the accept edge.
  task automatic send(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                      input logic chk, input logic [7:0] er, input logic [3:0] ef, input string nm);
    int t = 0;
    in_valid = 1'b1; sel = op; a = aa; b = bb;
    @(negedge clk);
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) probe({nm, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; sel = '0; a = '0; b = '0;
    if (chk) exp_q.push_back('{nm, er, ef});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic rdy_seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    probe("reset_state", {in_ready, out_valid, result, z, n, v, c}, {1'b1, 1'b0, 8'h00, 4'b0000});

    // Directed vectors: {z,n,v,c} expected.
    send(OP_ADD, 8'h7F, 8'h05, 1, 8'h84, 4'b0110, "add_ovf");
    probe("add_latency", {31'd0, out_valid}, 32'd1);
    send(OP_SUB, 8'hCC, 8'hCC, 1, 8'h00, 4'b1001, "sub_zero");
    send(OP_SUB, 8'd30, 8'd100, 1, 8'hBA, 4'b0100, "sub_borrow");
    send(OP_CMP, 8'd57, 8'd51, 1, 8'h39, 4'b0001, "cmp");
    send(OP_SHL, 8'h96, 8'd3, 1, 8'hB0, 4'b0100, "shl3");
    send(OP_ASR, 8'h96, 8'd2, 1, 8'hE5, 4'b0101, "asr2");
    send(OP_SHR, 8'h96, 8'd0, 1, 8'h96, 4'b0100, "shr0");
    send(OP_SHR, 8'h96, 8'd1, 1, 8'h4B, 4'b0000, "shr1");
    send(OP_SHL, 8'hC1, 8'd1, 1, 8'h82, 4'b0101, "shl1_carry");
    send(OP_XOR, 8'hAA, 8'hFF, 1, 8'h55, 4'b0000, "xor");
    send(OP_VCC, 8'h00, 8'h00, 1, 8'hFF, 4'b0100, "vcc");
    send(OP_NOP, 8'h12, 8'h34, 1, 8'h00, 4'b1000, "nop");
    send(OP_PASB, 8'h01, 8'h80, 1, 8'h80, 4'b0100, "pass_b");
    send(OP_PASA, 8'h7E, 8'h80, 1, 8'h7E, 4'b0000, "pass_a");
    send(OP_ADD, 8'hFF, 8'h01, 1, 8'h00, 4'b1001, "add_carry");
    send(OP_SUB, 8'h80, 8'h01, 1, 8'h7F, 4'b0011, "sub_ovf");
    send(OP_RSV, 8'h55, 8'h55, 1, 8'h00, 4'b1000, "reserved15");

`ifdef ALU_MUL_EN
    send(OP_MUL, 8'd13, 8'd11, 1, 8'h8F, 4'b0100, "mul_13x11");
    cyc = 0; rdy_seen = 1'b0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!out_valid && in_ready) rdy_seen = 1'b1;
    end
    probe("mul_latency", cyc, 32'd8);
    probe("mul_in_ready_low", {31'd0, rdy_seen}, 32'd0);
    send(OP_MUL, 8'h20, 8'h10, 1, 8'h00, 4'b1010, "mul_ovf");
    repeat (12) @(posedge clk);
`else
    send(OP_MUL, 8'd13, 8'd11, 1, 8'h00, 4'b1000, "op12_reserved");
    probe("op12_latency", {31'd0, out_valid}, 32'd1);
`endif

    // Backpressure: result held for 3 cycles, then a same-cycle accept on release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_OR, 8'h0F, 8'h30, 1, 8'h3F, 4'b0000, "or_held");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      probe("bp_stable", {in_ready, out_valid, result, z, n, v, c}, {1'b0, 1'b1, 8'h3F, 4'b0000});
    end
    out_ready = 1'b1;
    send(OP_AND, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, "and_after_bp");

    // Reset while a result is held: it must never be presented.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_ADD, 8'h03, 8'h04, 0, 8'h00, 4'b0000, "add_dropped");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    probe("rst_in_hold", {in_ready, out_valid, result, z, n, v, c}, {1'b1, 1'b0, 8'h00, 4'b0000});

`ifdef ALU_MUL_EN
    // Reset on the 4th multiply cycle.
    send(OP_MUL, 8'd5, 8'd6, 0, 8'h00, 4'b0000, "mul_aborted");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    probe("rst_in_mul", {in_ready, out_valid, result, z, n, v, c}, {1'b1, 1'b0, 8'h00, 4'b0000});
`endif
    send(OP_ADD, 8'h01, 8'h01, 1, 8'h02, 4'b0000, "add_after_rst");

    repeat (4) @(negedge clk);
    probe("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational datapath ALU. It registers every result and flag behind a valid/ready interface, adds XOR, arithmetic shift, compare and a carry flag, and optionally adds an iterative shift-add multiplier. It sits between the decode/operand-read stage and writeback, and can stall the pipeline during multi-cycle operations.

## Interface

- N, default 8, operand/result width; must be a power of 2 and at least 4.
- S = $clog2(N), derived (localparam), shift-amount width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  N  operand A.
- b  in  N  operand B. For shifts, b[S-1:0] is the shift amount.
- sel  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  N  registered result.
- z, n, v, c  out  1 each  zero, negative, overflow and carry flags, registered with result.

## Operation

- Opcodes:
  - 0 NOP: result 0.
  - 1 ADD: a+b.
  - 2 SUB: a-b.
  - 3 SHL: a<<b[S-1:0].
  - 4 SHR: logical right shift.
  - 5 AND.
  - 6 OR.
  - 7 PASS B.
  - 8 PASS A.
  - 9 VCC: result all ones.
  - 10 XOR.
  - 11 ASR: arithmetic right shift.
  - 12 MUL: low N bits of unsigned a*b.
  - 13 CMP: flags computed as for SUB; result = a.
  - 14, 15 reserved: result 0.
- Flags:
  - z = (result==0).
  - n = result[N-1].
  - CMP flags follow SUB, not the passed-through result.
  - ADD: c = carry out; v = signed overflow.
  - SUB/CMP: computed as a+~b+1. c = carry out (1 means no borrow). v = signed overflow.
  - Shifts: c = last bit shifted out; c = 0 when the amount is 0. v = 0.
  - MUL: v = 1 iff the upper N product bits are non-zero; c = 0.
  - All other ops: v = c = 0.
- FSM states IDLE, MUL, HOLD:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) with a single-cycle op loads result/flags and goes to HOLD. A MUL accept latches a, b, clears the accumulator and counter, and goes to MUL.
  - MUL: one multiplier bit per cycle, N cycles. On the final cycle, write result/flags and go to HOLD. in_ready=0.
  - HOLD: out_valid=1; result and flags stay stable until out_ready. in_ready = out_ready (combinational).
  - HOLD with out_ready & in_valid: the new op is accepted in the same cycle. A single-cycle op stays in HOLD with the new result. A MUL op goes to MUL.
  - HOLD with out_ready & !in_valid: go to IDLE.
- Operands and sel are sampled only at accept. Changes while in MUL or HOLD are ignored.

## Timing

- Reset values: state=IDLE, out_valid=0, result=0, z=n=v=c=0, counter=0. in_ready=1 in the first cycle after reset.
- Reset during MUL or HOLD aborts the operation; the partial result is discarded and never presented.
- Single-cycle op accepted at edge k: out_valid=1 after edge k. Back-to-back sustained throughput is 1 op/cycle with out_ready held at 1.
- MUL accepted at edge k: out_valid=1 after edge k+N (N cycles in MUL), i.e. after 8 cycles for N=8. in_ready=0 throughout.
- out_valid never deasserts without out_ready, except on rst.

## Configuration

- ALU_MUL_EN defined: MUL state, counter and accumulator are compiled in; opcode 12 behaves as above.
- ALU_MUL_EN undefined: no MUL state or multiplier logic. Opcode 12 is treated as reserved: single-cycle, result 0, z=1, n=v=c=0.

## Test plan

- ADD, N=8, a=0x7F, b=0x05 -> result 0x84, z=0, n=1, v=1, c=0, out_valid one cycle after accept.
- SUB a=0xCC, b=0xCC -> 0x00, z=1, c=1, v=0. Then SUB a=30, b=100 -> 0xBA, n=1, c=0, v=0. Then CMP a=57, b=51 -> result 57 (0x39), z=0, c=1.
- SHL a=0x96, b=3 -> 0xB0, c=0. ASR a=0x96, b=2 -> 0xE5, c=1. SHR a=0x96, b=0 -> 0x96, c=0.
- MUL (ALU_MUL_EN) a=13, b=11 -> 0x8F, v=0, out_valid 8 cycles after accept, in_ready=0 meanwhile. MUL a=0x20, b=0x10 -> 0x00, z=1, v=1. Without the macro, opcode 12 -> 0x00, z=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles after a result -> result/flags stable, in_ready=0. Then raise out_ready with in_valid=1 (AND 0xF0,0x3C) -> accepted same cycle, next result 0x30.
- Assert rst for one cycle at the 4th MUL cycle -> next cycle out_valid=0, result=0, flags 0, in_ready=1. A following ADD 1+1 -> 0x02.
